// File: rtl/tick_chain_pkg.sv
// Shared constants for the tick_chain prescaler: select width, 12 MHz default divisors,
// and a slice macro for the packed per-stage vectors.
`ifndef TICK_CHAIN_SLICE
`define TICK_CHAIN_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
`endif

package tick_chain_pkg;

    localparam int unsigned CFG_SEL_W = 3;

    // 12 MHz -> 1.25 us -> 8.33 ms -> 1 s
    localparam int unsigned DIV_1US25 = 15;
    localparam int unsigned DIV_120HZ = 6667;
    localparam int unsigned DIV_1HZ   = 120;

endpackage

// File: rtl/tick_chain_if.sv
// Control/pulse bundle of the tick_chain prescaler; o_cnt exists only with TICK_CHAIN_CNT_OUT_EN.
interface tick_chain_if #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned CNT_W      = 24
);
    import tick_chain_pkg::*;

    logic                        i_en;
    logic                        i_clear;
    logic                        i_cfg_we;
    logic [CFG_SEL_W-1:0]        i_cfg_sel;
    logic [CNT_W-1:0]            i_cfg_div;
    logic [NUM_STAGES-1:0]       o_pulse;
`ifdef TICK_CHAIN_CNT_OUT_EN
    logic [NUM_STAGES*CNT_W-1:0] o_cnt;
`endif

    modport master (
        output i_en, i_clear, i_cfg_we, i_cfg_sel, i_cfg_div,
`ifdef TICK_CHAIN_CNT_OUT_EN
        input  o_cnt,
`endif
        input  o_pulse
    );

    modport slave (
        input  i_en, i_clear, i_cfg_we, i_cfg_sel, i_cfg_div,
`ifdef TICK_CHAIN_CNT_OUT_EN
        output o_cnt,
`endif
        output o_pulse
    );

endinterface

// File: rtl/tick_chain_stage.sv
// One prescaler stage: counter, shadowed divisor and terminal-count compare.
// With TICK_CHAIN_CNT_OUT_EN the live counter is exported on cnt.
module tick_stage #(
    parameter int unsigned      CNT_W    = 24,
    parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef TICK_CHAIN_CNT_OUT_EN
    output logic [CNT_W-1:0] cnt,
`endif
    output logic             wrap_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] active_q;
    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] eff_c;

    // A zero divisor behaves as one; >= lets a shrunk divisor wrap on the next increment
    assign eff_c  = (active_q == '0) ? CNT_W'(1) : active_q;
    assign wrap_c = inc & (cnt_q >= (eff_c - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            active_q  <= DIV_INIT;
            pending_q <= DIV_INIT;
        end else begin
            if (cfg_we) begin
                pending_q <= cfg_div;
            end
            // active only reloads at a period boundary, so a period is never cut short
            if (clear) begin
                cnt_q    <= '0;
                active_q <= pending_q;
            end else if (wrap_c) begin
                cnt_q    <= '0;
                active_q <= pending_q;
            end else if (inc) begin
                cnt_q    <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef TICK_CHAIN_CNT_OUT_EN
    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/tick_chain.sv
// Cascaded prescaler producing NUM_STAGES nested, cycle-aligned one-cycle tick pulses.
// Optional macro TICK_CHAIN_CNT_OUT_EN exports the live stage counters on o_cnt.
module tick_chain
    import tick_chain_pkg::*;
#(
    parameter int unsigned                  NUM_STAGES = 3,
    parameter int unsigned                  CNT_W      = 24,
    parameter logic [NUM_STAGES*CNT_W-1:0]  DIV_INIT   = {CNT_W'(DIV_1HZ), CNT_W'(DIV_120HZ), CNT_W'(DIV_1US25)}
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    tick_chain_if.slave  bus
);

    logic [NUM_STAGES-1:0] inc_c;
    logic [NUM_STAGES-1:0] wrap_c;

    // Carry chain: each stage advances only when the one below wraps
    assign inc_c[0] = bus.i_en & ~bus.i_clear;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k > 0) begin : g_carry
            assign inc_c[k] = wrap_c[k-1];
        end

        tick_stage #(
            .CNT_W    (CNT_W),
            .DIV_INIT (`TICK_CHAIN_SLICE(DIV_INIT, k, CNT_W))
        ) u_stage (
            .clk     (i_clk),
            .rst_n   (i_reset_n),
            .inc     (inc_c[k]),
            .clear   (bus.i_clear),
            .cfg_we  (bus.i_cfg_we && (bus.i_cfg_sel == CFG_SEL_W'(k))),
            .cfg_div (bus.i_cfg_div),
`ifdef TICK_CHAIN_CNT_OUT_EN
            .cnt     (`TICK_CHAIN_SLICE(bus.o_cnt, k, CNT_W)),
`endif
            .wrap_c  (wrap_c[k])
        );
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bus.o_pulse <= '0;
        end else begin
            bus.o_pulse <= wrap_c;
        end
    end

endmodule

// File: tb/tb_tick_chain.sv
// Self-checking bench for tick_chain: per-cycle comparison against a behavioural model
// plus directed period measurements with hand-computed expectations.
module tb_tick_chain;

    localparam int unsigned N  = 3;
    localparam int unsigned CW = 24;

    logic clk;
    logic rst_n;

    tick_chain_if #(.NUM_STAGES(N), .CNT_W(CW)) bus ();

    tick_chain dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: integer counts and divisors per stage
    int           m_cnt  [N];
    int           m_act  [N];
    int           m_pend [N];
    logic [N-1:0] exp_pulse;

    task automatic model_reset();
        m_act[0] = 15;  m_act[1] = 6667;  m_act[2] = 120;
        for (int k = 0; k < N; k++) begin
            m_cnt[k]  = 0;
            m_pend[k] = m_act[k];
        end
        exp_pulse = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            logic         carry;
            logic [N-1:0] wr;
            int           eff;
            carry = bus.i_en && !bus.i_clear;
            wr    = '0;
            for (int k = 0; k < N; k++) begin
                if (carry) begin
                    eff = (m_act[k] == 0) ? 1 : m_act[k];
                    if (m_cnt[k] + 1 >= eff) begin
                        wr[k]    = 1'b1;
                        m_cnt[k] = 0;
                        m_act[k] = m_pend[k];
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                        carry    = 1'b0;
                    end
                end
            end
            if (bus.i_clear) begin
                for (int k = 0; k < N; k++) begin
                    m_cnt[k] = 0;
                    m_act[k] = m_pend[k];
                end
            end
            if (bus.i_cfg_we && (int'(bus.i_cfg_sel) < N))
                m_pend[bus.i_cfg_sel] = int'(bus.i_cfg_div);
            exp_pulse = wr;
        end
    end

    // Compare process: every falling edge outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (bus.o_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL model_pulse t=%0t got=%b exp=%b", $time, bus.o_pulse, exp_pulse);
            end
`ifdef TICK_CHAIN_CNT_OUT_EN
            begin
                logic [N*CW-1:0] ec;
                for (int k = 0; k < N; k++) ec[k*CW +: CW] = CW'(m_cnt[k]);
                n_cmp++;
                if (bus.o_cnt !== ec) begin
                    n_fail++;
                    $display("FAIL model_cnt t=%0t got=%h exp=%h", $time, bus.o_cnt, ec);
                end
            end
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Count cycles until o_pulse[idx] is seen; -1 if the budget runs out
    task automatic wait_pulse(input int idx, input int budget, output int n);
        n = 0;
        while (1) begin
            step();
            n++;
            if (bus.o_pulse[idx]) return;
            if (n >= budget) begin
                n = -1;
                return;
            end
        end
    endtask

    task automatic cfg_write(input int sel, input int div);
        bus.i_cfg_we  = 1'b1;
        bus.i_cfg_sel = 3'(sel);
        bus.i_cfg_div = CW'(div);
        step();
        bus.i_cfg_we  = 1'b0;
    endtask

    task automatic do_clear();
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
    endtask

    initial begin
        int n;
        int tot;
        rst_n         = 1'b0;
        bus.i_en      = 1'b0;
        bus.i_clear   = 1'b0;
        bus.i_cfg_we  = 1'b0;
        bus.i_cfg_sel = '0;
        bus.i_cfg_div = '0;
        #23;
        check("reset_pulse", int'(bus.o_pulse), 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset divisors: first pulse at 15, then every 15
        bus.i_en = 1'b1;
        wait_pulse(0, 40, n);  check("dflt_first0", n, 15);
        wait_pulse(0, 40, n);  check("dflt_period0", n, 15);
        check("dflt_only0", int'(bus.o_pulse), 1);

        // Divisors 3/2/2
        bus.i_en = 1'b0;
        cfg_write(0, 3); cfg_write(1, 2); cfg_write(2, 2);
        do_clear();
        bus.i_en = 1'b1;
        wait_pulse(1, 40, n);  check("d322_first1", n, 6);
        wait_pulse(2, 40, n);  check("d322_first2", n, 6);
        check("d322_coinc", int'(bus.o_pulse), 7);
        wait_pulse(1, 40, n);  check("d322_period1", n, 6);
        wait_pulse(2, 40, n);  check("d322_second2", n, 6);

        // Shadowing: write div0=4 while cnt[0]=5 under div 15
        bus.i_en = 1'b0;
        cfg_write(0, 15);
        do_clear();
        bus.i_en = 1'b1;
        repeat (5) step();
        cfg_write(0, 4);
        wait_pulse(0, 40, n);  check("shadow_rest", n, 9);
        wait_pulse(0, 40, n);  check("shadow_new", n, 4);

        // Enable gap of 7 cycles delays the pulse by 7
        bus.i_en = 1'b0;
        cfg_write(0, 15);
        do_clear();
        bus.i_en = 1'b1;
        repeat (5) step();
        bus.i_en = 1'b0;
        repeat (7) begin
            step();
            check("en_low_quiet", int'(bus.o_pulse), 0);
        end
        bus.i_en = 1'b1;
        wait_pulse(0, 40, n);  tot = 12 + n;
        check("en_gap_total", tot, 22);

        // Clear at cnt[0]=9
        repeat (9) step();
        bus.i_clear = 1'b1;
        step();
        check("clear_no_pulse", int'(bus.o_pulse), 0);
        bus.i_clear = 1'b0;
        wait_pulse(0, 40, n);  check("clear_restart", n, 15);

        // Divisor 0 and 1: pulse every enabled cycle; sel 5 ignored
        for (int d = 0; d < 2; d++) begin
            bus.i_en = 1'b0;
            cfg_write(0, d);
            do_clear();
            bus.i_en = 1'b1;
            repeat (4) begin
                step();
                check("div01_every", int'(bus.o_pulse[0]), 1);
            end
        end
        cfg_write(5, 7);
        do_clear();
        repeat (3) begin
            step();
            check("sel5_ignored", int'(bus.o_pulse[0]), 1);
        end

        // Randomised phase, checked cycle by cycle against the model
        bus.i_en = 1'b0;
        cfg_write(0, 3); cfg_write(1, 2); cfg_write(2, 3);
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            bus.i_en      = ($urandom_range(0, 9) < 8);
            bus.i_clear   = ($urandom_range(0, 99) < 2);
            bus.i_cfg_we  = ($urandom_range(0, 99) < 5);
            bus.i_cfg_sel = 3'($urandom_range(0, 7));
            bus.i_cfg_div = CW'($urandom_range(0, 5));
            step();
        end
        bus.i_en = 1'b0; bus.i_clear = 1'b0; bus.i_cfg_we = 1'b0;

        // Async reset mid-cycle with a pending write outstanding
        cfg_write(0, 0);
        do_clear();
        bus.i_en = 1'b1;
        step();
        check("pre_reset_pulse", int'(bus.o_pulse[0]), 1);
        cfg_write(0, 9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_pulse", int'(bus.o_pulse), 0);
        step();
        rst_n = 1'b1;
        wait_pulse(0, 40, n);  check("post_reset_first", n, 15);
        wait_pulse(0, 40, n);  check("post_reset_period", n, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
